// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Issue/hazard controller for a 5-stage MIPS pipeline. It sits
//               between ID and the ID/EX register, stalls fetch and injects
//               bubbles on RAW hazards using a scoreboard shift register of
//               in-flight register writes. It also sequences run start,
//               exception drain and halt, and keeps saturating issue/stall
//               counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter int RF_BYPASS = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             exception,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_uses_rs,
  input  logic             dec_uses_rt,
  input  logic             dec_wr_en,
  input  logic [4:0]       dec_wr_addr,
  output logic             fetch_en,
  output logic             bubble,
  output logic             issue,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  // With a bypassing register file the oldest slot writes in the same cycle
  // the consumer reads, so that slot can never cause a hazard.
  localparam int               c_NCHK    = (RF_BYPASS != 0) ? DEPTH - 1 : DEPTH;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      slot_vld_q, slot_vld_d;
  logic [DEPTH-1:0][4:0] slot_addr_q, slot_addr_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0]      w_rs_hit;
  logic [DEPTH-1:0]      w_rt_hit;
  logic                  w_rs_hazard;
  logic                  w_rt_hazard;
  logic                  w_hazard;
  logic                  w_busy;

  // Per-slot address compare; unchecked slots never report a hit.
  for (genvar gk = 0; gk < DEPTH; gk++) begin : g_slot_cmp
    if (gk < c_NCHK) begin : g_checked
      assign w_rs_hit[gk] = slot_vld_q[gk] & (slot_addr_q[gk] == dec_rs);
      assign w_rt_hit[gk] = slot_vld_q[gk] & (slot_addr_q[gk] == dec_rt);
    end else begin : g_unchecked
      assign w_rs_hit[gk] = 1'b0;
      assign w_rt_hit[gk] = 1'b0;
    end
  end

  // $0 is hard-wired to zero, so a read of it can never depend on a write.
  assign w_rs_hazard = dec_uses_rs & (dec_rs != 5'd0) & (|w_rs_hit);
  assign w_rt_hazard = dec_uses_rt & (dec_rt != 5'd0) & (|w_rt_hit);
  assign w_hazard    = dec_valid & (w_rs_hazard | w_rt_hazard);
  assign w_busy      = |slot_vld_q;

  assign halted    = (state_q == S_HALT);
  assign busy      = w_busy;
  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Pipeline control: only RUN lets instructions through; an exception
  // squashes the instruction currently in ID.
  always_comb begin
    fetch_en = 1'b0;
    issue    = 1'b0;
    bubble   = 1'b1;
    if (state_q == S_RUN) begin
      fetch_en = ~w_hazard;
      issue    = dec_valid & ~w_hazard & ~exception;
      bubble   = w_hazard | ~dec_valid | exception;
    end
  end

  // Run sequencing: IDLE -> RUN -> DRAIN -> HALT, HALT sticky until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (exception) state_d = S_DRAIN;
      S_DRAIN: if (!w_busy)   state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Scoreboard shift: the issued write (if any, and not to $0) enters slot 0.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    if (state_q != S_IDLE) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slot_vld_d[k]  = slot_vld_q[k-1];
        slot_addr_d[k] = slot_addr_q[k-1];
      end
      slot_vld_d[0]  = issue & dec_wr_en & (dec_wr_addr != 5'd0);
      slot_addr_d[0] = dec_wr_addr;
    end
  end

  // Saturating performance counters.
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue && (issue_cnt_q != c_CNT_MAX)) begin
      issue_cnt_d = issue_cnt_q + c_CNT_ONE;
    end
    if ((state_q == S_RUN) && w_hazard && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + c_CNT_ONE;
    end
  end

  // State, scoreboard and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slot_vld_q  <= '0;
      slot_addr_q <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Two instances run on
//               the same stimulus: A (DEPTH=3, no RF bypass, 16-bit counters)
//               and B (DEPTH=3, RF bypass, 4-bit counters). A directed table,
//               a counter-saturation sequence and random stimulus are checked
//               against a register-age reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, exception, dec_valid, dec_uses_rs, dec_uses_rt, dec_wr_en;
  logic [4:0] dec_rs, dec_rt, dec_wr_addr;

  logic        a_fetch, a_bubble, a_issue, a_halted, a_busy;
  logic [15:0] a_icnt, a_scnt;
  logic        b_fetch, b_bubble, b_issue, b_halted, b_busy;
  logic [3:0]  b_icnt, b_scnt;

  pipe_hazard_ctrl #(.DEPTH(3), .RF_BYPASS(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .exception(exception),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr),
    .fetch_en(a_fetch), .bubble(a_bubble), .issue(a_issue), .halted(a_halted),
    .busy(a_busy), .issue_cnt(a_icnt), .stall_cnt(a_scnt));

  pipe_hazard_ctrl #(.DEPTH(3), .RF_BYPASS(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .exception(exception),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr),
    .fetch_en(b_fetch), .bubble(b_bubble), .issue(b_issue), .halted(b_halted),
    .busy(b_busy), .issue_cnt(b_icnt), .stall_cnt(b_scnt));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance remembers, per architectural register, the cycle in which
  // its latest write issued. A write is still pending while its age is within
  // the window of stages that have not yet written the register file.
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_DRAIN = 2, MD_HALT = 3;
  int m_depth [2] = '{3, 3};
  int m_nchk  [2] = '{3, 2};
  int m_cmax  [2] = '{65535, 15};
  int m_mode  [2];
  int m_now   [2];
  int m_icnt  [2];
  int m_scnt  [2];
  int m_lw    [2][32];

  function automatic void m_reset(int m);
    m_mode[m] = MD_IDLE;
    m_now[m]  = 0;
    m_icnt[m] = 0;
    m_scnt[m] = 0;
    for (int r = 0; r < 32; r++) m_lw[m][r] = -1000;
  endfunction

  function automatic bit m_pend(int m, int r, int win);
    int age;
    age = m_now[m] - m_lw[m][r];
    return (r != 0) && (age >= 1) && (age <= win);
  endfunction

  function automatic void m_eval(int m, output bit fe, output bit bu, output bit is,
                                 output bit ha, output bit bz, output bit hz);
    bit hit;
    hit = (dec_uses_rs && m_pend(m, int'(dec_rs), m_nchk[m])) ||
          (dec_uses_rt && m_pend(m, int'(dec_rt), m_nchk[m]));
    hz = dec_valid && hit;
    bz = 1'b0;
    for (int r = 1; r < 32; r++) if (m_pend(m, r, m_depth[m])) bz = 1'b1;
    ha = (m_mode[m] == MD_HALT);
    if (m_mode[m] == MD_RUN) begin
      fe = !hz;
      is = dec_valid && !hz && !exception;
      bu = !is;
    end else begin
      fe = 1'b0;
      is = 1'b0;
      bu = 1'b1;
    end
  endfunction

  function automatic void m_step(int m);
    bit fe, bu, is, ha, bz, hz;
    if (rst) begin
      m_reset(m);
      return;
    end
    m_eval(m, fe, bu, is, ha, bz, hz);
    case (m_mode[m])
      MD_IDLE:  if (start) m_mode[m] = MD_RUN;
      MD_RUN: begin
        if (is && dec_wr_en && dec_wr_addr != 5'd0) m_lw[m][dec_wr_addr] = m_now[m];
        if (is && m_icnt[m] < m_cmax[m]) m_icnt[m]++;
        if (hz && m_scnt[m] < m_cmax[m]) m_scnt[m]++;
        if (exception) m_mode[m] = MD_DRAIN;
      end
      MD_DRAIN: if (!bz) m_mode[m] = MD_HALT;
      default: ;
    endcase
    m_now[m]++;
  endfunction

  // Compare both DUTs with the model, advance the model, move to next negedge.
  task automatic run_cycle();
    bit fe, bu, is, ha, bz, hz;
    m_eval(0, fe, bu, is, ha, bz, hz);
    chk("A fetch_en", a_fetch, fe);
    chk("A bubble", a_bubble, bu);
    chk("A issue", a_issue, is);
    chk("A halted", a_halted, ha);
    chk("A busy", a_busy, bz);
    chk("A issue_cnt", a_icnt, m_icnt[0]);
    chk("A stall_cnt", a_scnt, m_scnt[0]);
    m_eval(1, fe, bu, is, ha, bz, hz);
    chk("B fetch_en", b_fetch, fe);
    chk("B bubble", b_bubble, bu);
    chk("B issue", b_issue, is);
    chk("B halted", b_halted, ha);
    chk("B busy", b_busy, bz);
    chk("B issue_cnt", b_icnt, m_icnt[1]);
    chk("B stall_cnt", b_scnt, m_scnt[1]);
    m_step(0);
    m_step(1);
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit       rst, start, exc, dv, urs, urt, we;
    bit [4:0] rs, rt, wa;
    bit       ef, eb, ei, eh, ez;   // expected fetch_en, bubble, issue, halted, busy (instance A)
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, bit e, bit dv, bit urs, int rs, bit urt, int rt,
                              bit we, int wa, bit ef, bit eb, bit ei, bit eh, bit ez);
    vec_t v;
    v.rst = r; v.start = s; v.exc = e; v.dv = dv;
    v.urs = urs; v.rs = 5'(rs); v.urt = urt; v.rt = 5'(rt);
    v.we = we; v.wa = 5'(wa);
    v.ef = ef; v.eb = eb; v.ei = ei; v.eh = eh; v.ez = ez;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; start = v.start; exception = v.exc; dec_valid = v.dv;
    dec_uses_rs = v.urs; dec_rs = v.rs; dec_uses_rt = v.urt; dec_rt = v.rt;
    dec_wr_en = v.we; dec_wr_addr = v.wa;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle_v;
    //            r s e dv urs rs urt rt we wa  ef eb ei eh ez
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,  0,1,0,0,0));  // 0  reset
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,  0,1,0,0,0));  // 1  reset
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0,0,  0,1,0,0,0));  // 2  start in IDLE
    tbl.push_back(mk(0,0,0,1, 0,0, 0,0, 1,3,  1,0,1,0,0));  // 3  producer $3
    tbl.push_back(mk(0,0,0,1, 1,3, 0,0, 0,0,  0,1,0,0,1));  // 4  consumer stalls
    tbl.push_back(mk(0,0,0,1, 1,3, 0,0, 0,0,  0,1,0,0,1));  // 5
    tbl.push_back(mk(0,0,0,1, 1,3, 0,0, 0,0,  0,1,0,0,1));  // 6
    tbl.push_back(mk(0,0,0,1, 1,3, 0,0, 0,0,  1,0,1,0,0));  // 7  issues on 4th cycle
    tbl.push_back(mk(0,0,0,1, 0,0, 0,0, 1,0,  1,0,1,0,0));  // 8  writes $0
    tbl.push_back(mk(0,0,0,1, 1,0, 1,0, 1,0,  1,0,1,0,0));  // 9  reads $0 twice
    tbl.push_back(mk(0,0,0,1, 1,2, 0,0, 1,5,  1,0,1,0,0));  // 10 load $5
    tbl.push_back(mk(0,0,0,1, 1,7, 0,0, 0,0,  1,0,1,0,1));  // 11 independent
    tbl.push_back(mk(0,0,0,1, 1,9, 1,5, 0,0,  0,1,0,0,1));  // 12 store rt=$5 (slot1)
    tbl.push_back(mk(0,0,0,1, 1,9, 1,5, 0,0,  0,1,0,0,1));  // 13
    tbl.push_back(mk(0,0,0,1, 1,9, 1,5, 0,0,  1,0,1,0,0));  // 14 issues
    tbl.push_back(mk(0,0,0,1, 1,2, 0,0, 1,5,  1,0,1,0,0));  // 15 load $5
    tbl.push_back(mk(0,0,0,1, 1,7, 0,0, 0,0,  1,0,1,0,1));  // 16 independent
    tbl.push_back(mk(0,0,0,1, 1,9, 0,5, 0,0,  1,0,1,0,1));  // 17 rt not used
    tbl.push_back(mk(0,0,0,1, 0,0, 0,0, 1,6,  1,0,1,0,1));  // 18 producer $6
    tbl.push_back(mk(0,0,0,1, 1,6, 0,0, 0,0,  0,1,0,0,1));  // 19 hazard
    tbl.push_back(mk(0,0,1,1, 1,6, 0,0, 0,0,  0,1,0,0,1));  // 20 exception + hazard
    tbl.push_back(mk(0,0,0,1, 1,6, 0,0, 0,0,  0,1,0,0,1));  // 21 DRAIN
    tbl.push_back(mk(0,0,0,1, 1,6, 0,0, 0,0,  0,1,0,0,0));  // 22 DRAIN, empty
    tbl.push_back(mk(0,1,0,1, 0,0, 0,0, 0,0,  0,1,0,1,0));  // 23 HALT, start ignored
    tbl.push_back(mk(0,1,1,1, 0,0, 0,0, 0,0,  0,1,0,1,0));  // 24 HALT, start+exc
    tbl.push_back(mk(0,0,0,1, 0,0, 0,0, 0,0,  0,1,0,1,0));  // 25 HALT
    tbl.push_back(mk(1,0,0,1, 0,0, 0,0, 0,0,  0,1,0,1,0));  // 26 rst from HALT
    tbl.push_back(mk(0,1,0,0, 0,0, 0,0, 0,0,  0,1,0,0,0));  // 27 start
    tbl.push_back(mk(0,0,0,1, 0,0, 0,0, 1,4,  1,0,1,0,0));  // 28 producer $4
    tbl.push_back(mk(0,0,1,1, 1,4, 0,0, 0,0,  0,1,0,0,1));  // 29 exception
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0,  0,1,0,0,1));  // 30 rst during DRAIN
    tbl.push_back(mk(0,0,0,1, 1,4, 0,0, 0,0,  0,1,0,0,0));  // 31 IDLE again

    idle_v = mk(0,0,0,0, 0,0, 0,0, 0,0, 0,0,0,0,0);
    m_reset(0);
    m_reset(1);
    drive(tbl[0]);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("tbl[%0d] fetch_en", i), a_fetch,  tbl[i].ef);
      chk($sformatf("tbl[%0d] bubble", i),   a_bubble, tbl[i].eb);
      chk($sformatf("tbl[%0d] issue", i),    a_issue,  tbl[i].ei);
      chk($sformatf("tbl[%0d] halted", i),   a_halted, tbl[i].eh);
      chk($sformatf("tbl[%0d] busy", i),     a_busy,   tbl[i].ez);
      if (i == 8) begin
        chk("A stall_cnt after 3-cycle stall", a_scnt, 3);
        chk("B stall_cnt after bypass stall", b_scnt, 2);
        chk("A issue_cnt after producer/consumer", a_icnt, 2);
      end
      if (i == 10) chk("A stall_cnt unchanged by $0", a_scnt, 3);
      if (i == 15) begin
        chk("A stall_cnt after store stall", a_scnt, 5);
        chk("B stall_cnt after store stall", b_scnt, 3);
      end
      if (i == 31) begin
        chk("A issue_cnt cleared", a_icnt, 0);
        chk("A stall_cnt cleared", a_scnt, 0);
        chk("B issue_cnt cleared", b_icnt, 0);
      end
      run_cycle();
    end

    // Counter saturation: 23 back-to-back independent issues.
    idle_v.start = 1'b1;
    drive(idle_v);
    #1;
    run_cycle();
    idle_v.start = 1'b0;
    idle_v.dv    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(idle_v);
      #1;
      run_cycle();
    end
    chk("B issue_cnt saturates", b_icnt, 15);
    chk("A issue_cnt after 20", a_icnt, 20);
    for (int i = 0; i < 3; i++) begin
      drive(idle_v);
      #1;
      run_cycle();
    end
    chk("B issue_cnt holds", b_icnt, 15);
    chk("A issue_cnt after 23", a_icnt, 23);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 5) == 0);
      exception   = ($urandom_range(0, 59) == 0);
      dec_valid   = ($urandom_range(0, 3) != 0);
      dec_uses_rs = $urandom_range(0, 1) != 0;
      dec_uses_rt = $urandom_range(0, 1) != 0;
      dec_wr_en   = $urandom_range(0, 1) != 0;
      dec_rs      = 5'($urandom_range(0, 7));
      dec_rt      = 5'($urandom_range(0, 7));
      dec_wr_addr = 5'($urandom_range(0, 7));
      #1;
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
